// File: rtl/fitness_eval_ctrl.sv
// Evaluation-pass sequencer: loads the energy config into fitness_eval, streams the population
// through it, writes the returned energies to the fitness RAM. Optional macro: FIT_BEST_TRACK_EN.
module fitness_eval_ctrl #(
   parameter int NUM_PARTICLE_TYPE = 3,
   parameter int DATA_WIDTH        = 4,
   parameter int PARTICLE_LENGTH   = 2,
   parameter int LATTICE_LENGTH    = 11,
   parameter int SELF_FIT_LENGTH   = 10,
   parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH*PARTICLE_LENGTH,
   parameter int POP_SIZE          = 50,
   parameter int IDX_WIDTH         = 6
) (
   input  logic                                                  clk_i,
   input  logic                                                  rst_n,
   input  logic                                                  start_i,
   input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               self_energy_vec_i,
   input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
   output logic                                                  busy_o,
   output logic                                                  done_o,
   output logic                                                  err_o,
   output logic                                                  pop_rd_en_o,
   output logic [IDX_WIDTH-1:0]                                  pop_rd_addr_o,
   input  logic [INDIVIDUAL_LENGTH-1:0]                          pop_rd_data_i,
   output logic                                                  fe_set_data_o,
   output logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               fe_self_energy_vec_o,
   output logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] fe_interact_matrix_o,
   output logic                                                  fe_in_valid_o,
   output logic [INDIVIDUAL_LENGTH-1:0]                          fe_individual_vec_o,
   output logic [IDX_WIDTH-1:0]                                  fe_ind_idx_o,
   input  logic                                                  fe_out_valid_i,
   input  logic [SELF_FIT_LENGTH-1:0]                            fe_total_energy_i,
   input  logic [IDX_WIDTH-1:0]                                  fe_ind_wb_idx_i,
   output logic                                                  fit_wr_en_o,
   output logic [IDX_WIDTH-1:0]                                  fit_wr_addr_o,
   output logic [SELF_FIT_LENGTH-1:0]                            fit_wr_data_o,
   output logic [SELF_FIT_LENGTH-1:0]                            best_energy_o,
   output logic [IDX_WIDTH-1:0]                                  best_idx_o
);
   localparam int SE_W = NUM_PARTICLE_TYPE*DATA_WIDTH;
   localparam int IM_W = NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE-1);
   localparam logic [IDX_WIDTH-1:0] POP_CNT  = IDX_WIDTH'(POP_SIZE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CFG   = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                     state_r, state_s;
   logic [IDX_WIDTH-1:0]       iss_cnt_r, iss_cnt_s;
   logic [IDX_WIDTH-1:0]       ret_cnt_r, ret_cnt_s;
   logic                       start_acc_s, ret_fire_s;
   logic                       set_data_s, rd_en_s, done_s;
   logic                       busy_r, done_r, err_r, set_data_r, rd_en_r, in_valid_r;
   logic [IDX_WIDTH-1:0]       ind_idx_r;
   logic [SE_W-1:0]            se_r;
   logic [IM_W-1:0]            im_r;
   logic                       wr_en_r;
   logic [IDX_WIDTH-1:0]       wr_addr_r;
   logic [SELF_FIT_LENGTH-1:0] wr_data_r;

   // Next-state, counter and strobe decode for the pass sequencer
   always_comb begin
      state_s     = state_r;
      iss_cnt_s   = iss_cnt_r;
      start_acc_s = 1'b0;
      set_data_s  = 1'b0;
      rd_en_s     = 1'b0;
      done_s      = 1'b0;
      ret_fire_s  = fe_out_valid_i && (state_r != IDLE);
      if (ret_fire_s) begin
         ret_cnt_s = ret_cnt_r + IDX_WIDTH'(1);
      end else begin
         ret_cnt_s = ret_cnt_r;
      end
      case (state_r)
         IDLE: begin
            if (start_i) begin
               start_acc_s = 1'b1;
               set_data_s  = 1'b1;
               iss_cnt_s   = {IDX_WIDTH{1'b0}};
               ret_cnt_s   = {IDX_WIDTH{1'b0}};
               state_s     = CFG;
            end else begin
               state_s = IDLE;
            end
         end
         CFG: begin
            rd_en_s = 1'b1;
            state_s = ISSUE;
         end
         ISSUE: begin
            // rd_en_r already covers the read at iss_cnt_r; decide whether another follows
            if (iss_cnt_r == LAST_IDX) begin
               iss_cnt_s = {IDX_WIDTH{1'b0}};
               state_s   = DRAIN;
            end else begin
               iss_cnt_s = iss_cnt_r + IDX_WIDTH'(1);
               rd_en_s   = 1'b1;
               state_s   = ISSUE;
            end
         end
         DRAIN: begin
            // Finishing on the same edge as the last result keeps done_o aligned with its write
            if (ret_cnt_s == POP_CNT) begin
               done_s  = 1'b1;
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Sequencer state, issue pipeline, captured config and fitness write-back registers
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         iss_cnt_r  <= {IDX_WIDTH{1'b0}};
         ret_cnt_r  <= {IDX_WIDTH{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         set_data_r <= 1'b0;
         rd_en_r    <= 1'b0;
         in_valid_r <= 1'b0;
         ind_idx_r  <= {IDX_WIDTH{1'b0}};
         se_r       <= {SE_W{1'b0}};
         im_r       <= {IM_W{1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {IDX_WIDTH{1'b0}};
         wr_data_r  <= {SELF_FIT_LENGTH{1'b0}};
      end else begin
         state_r    <= state_s;
         iss_cnt_r  <= iss_cnt_s;
         ret_cnt_r  <= ret_cnt_s;
         busy_r     <= (state_s != IDLE);
         done_r     <= done_s;
         set_data_r <= set_data_s;
         rd_en_r    <= rd_en_s;
         in_valid_r <= rd_en_r;
         if (rd_en_r) begin
            ind_idx_r <= iss_cnt_r;
         end
         if (start_acc_s) begin
            se_r <= self_energy_vec_i;
            im_r <= interact_matrix_i;
         end
         // Out-of-order return is flagged but the write still lands where the evaluator says
         if (start_acc_s) begin
            err_r <= 1'b0;
         end else if (ret_fire_s && (fe_ind_wb_idx_i != ret_cnt_r)) begin
            err_r <= 1'b1;
         end
         wr_en_r <= ret_fire_s;
         if (ret_fire_s) begin
            wr_addr_r <= fe_ind_wb_idx_i;
            wr_data_r <= fe_total_energy_i;
         end
      end
   end

`ifdef FIT_BEST_TRACK_EN
   logic [SELF_FIT_LENGTH-1:0] best_e_r;
   logic [IDX_WIDTH-1:0]       best_i_r;

   // Running minimum; strict less-than keeps the earliest index on ties
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         best_e_r <= {SELF_FIT_LENGTH{1'b1}};
         best_i_r <= {IDX_WIDTH{1'b0}};
      end else if (start_acc_s) begin
         best_e_r <= {SELF_FIT_LENGTH{1'b1}};
         best_i_r <= {IDX_WIDTH{1'b0}};
      end else if (ret_fire_s && (fe_total_energy_i < best_e_r)) begin
         best_e_r <= fe_total_energy_i;
         best_i_r <= fe_ind_wb_idx_i;
      end
   end

   assign best_energy_o = best_e_r;
   assign best_idx_o    = best_i_r;
`else
   assign best_energy_o = {SELF_FIT_LENGTH{1'b0}};
   assign best_idx_o    = {IDX_WIDTH{1'b0}};
`endif

   assign busy_o               = busy_r;
   assign done_o               = done_r;
   assign err_o                = err_r;
   assign pop_rd_en_o          = rd_en_r;
   assign pop_rd_addr_o        = iss_cnt_r;
   assign fe_set_data_o        = set_data_r;
   assign fe_self_energy_vec_o = se_r;
   assign fe_interact_matrix_o = im_r;
   assign fe_in_valid_o        = in_valid_r;
   assign fe_ind_idx_o         = ind_idx_r;
   assign fe_individual_vec_o  = in_valid_r ? pop_rd_data_i : {INDIVIDUAL_LENGTH{1'b0}};
   assign fit_wr_en_o          = wr_en_r;
   assign fit_wr_addr_o        = wr_addr_r;
   assign fit_wr_data_o        = wr_data_r;

endmodule
